// File: rtl/div_aq_shift_register.sv
// Partial-remainder (A) and dividend/quotient (Q) register pair for a restoring divider.
// Supports load, joint {A,Q} left shift and A write-back with quotient-bit insertion.
module div_aq_shift_register #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic             shl,
    input  logic             wr_a,
    input  logic [WIDTH:0]   a_in,
    input  logic             q_bit,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             done,
    output logic             overrun
);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loaded_q, loaded_d;
    logic             pend_q, pend_d;
    logic             overrun_q, overrun_d;

    // Commands are mutually exclusive by priority: ld, then shl, then wr_a.
    always_comb begin
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        loaded_d  = loaded_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        if (ld) begin
            a_d       = '0;
            q_d       = dividend_in;
            cnt_d     = CNT_W'(WIDTH);
            loaded_d  = 1'b1;
            pend_d    = 1'b0;
            overrun_d = 1'b0;
        end else if (shl) begin
            if (cnt_q != '0) begin
                a_d    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                q_d    = {q_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                pend_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (wr_a) begin
            a_d    = a_in;
            q_d    = {q_q[WIDTH-1:1], q_bit};
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            loaded_q  <= 1'b0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            loaded_q  <= loaded_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    // done waits for the write-back that follows the last shift.
    assign done    = loaded_q & (cnt_q == '0) & ~pend_q;
    assign a_out   = a_q;
    assign q_out   = q_q;
    assign cnt_out = cnt_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_div_aq_shift_register.sv
// Bench for div_aq_shift_register: vector table, directed corner sequences,
// full divisions at WIDTH 16 and 8, and a random command stream against a model.
module tb_div_aq_shift_register;
    localparam int W  = 16;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          ld, shl, wr_a, q_bit;
    logic [W-1:0]  din;
    logic [W:0]    a_in;
    logic [W:0]    a_out;
    logic [W-1:0]  q_out;
    logic [4:0]    cnt_out;
    logic          done, overrun;

    logic          ld8, shl8, wr8, qb8;
    logic [W8-1:0] din8;
    logic [W8:0]   ain8;
    logic [W8:0]   aout8;
    logic [W8-1:0] qout8;
    logic [3:0]    cnt8;
    logic          done8, ovr8;

    div_aq_shift_register #(.WIDTH(W)) dut16 (
        .clk(clk), .rst(rst), .ld(ld), .dividend_in(din), .shl(shl), .wr_a(wr_a),
        .a_in(a_in), .q_bit(q_bit), .a_out(a_out), .q_out(q_out), .cnt_out(cnt_out),
        .done(done), .overrun(overrun));

    div_aq_shift_register #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .ld(ld8), .dividend_in(din8), .shl(shl8), .wr_a(wr8),
        .a_in(ain8), .q_bit(qb8), .a_out(aout8), .q_out(qout8), .cnt_out(cnt8),
        .done(done8), .overrun(ovr8));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld = 1'b0; shl = 1'b0; wr_a = 1'b0; q_bit = 1'b0; din = '0; a_in = '0;
        ld8 = 1'b0; shl8 = 1'b0; wr8 = 1'b0; qb8 = 1'b0; din8 = '0; ain8 = '0;
    endtask

    typedef struct {
        logic         ld, shl, wr;
        logic [15:0]  din;
        logic [16:0]  ain;
        logic         qb;
        logic [16:0]  ea;
        logic [15:0]  eq;
        logic [4:0]   ec;
        logic         ed, eo;
    } vec_t;
    vec_t tbl[9];

    // Restoring division on the 16-bit instance; datapath modelled here,
    // results checked against integer / and %.
    task automatic div16(input logic [W-1:0] dd, input logic [W-1:0] dv);
        logic [W:0] diff;
        ld = 1'b1; din = dd; tick(); ld = 1'b0;
        for (int i = 0; i < W; i++) begin
            shl = 1'b1; tick(); shl = 1'b0;
            diff = a_out - {1'b0, dv};
            wr_a = 1'b1;
            if (diff[W]) begin a_in = a_out; q_bit = 1'b0; end
            else         begin a_in = diff;  q_bit = 1'b1; end
            if (i == W - 1) chk("div16_done_before_last_wr", 64'(done), 64'd0);
            tick(); wr_a = 1'b0;
        end
        chk("div16_quotient", 64'(q_out), 64'(dd / dv));
        chk("div16_remainder", 64'(a_out), 64'(dd % dv));
        chk("div16_done", 64'(done), 64'd1);
        chk("div16_cnt", 64'(cnt_out), 64'd0);
    endtask

    logic [2*W:0] m_aq;
    int           m_cnt;
    bit           m_loaded, m_pend, m_ovr;

    initial begin
        idle();
        rst = 1'b0;
        #12;
        chk("reset_a", 64'(a_out), 64'd0);
        chk("reset_q", 64'(q_out), 64'd0);
        chk("reset_cnt", 64'(cnt_out), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_ovr", 64'(overrun), 64'd0);
        @(negedge clk); rst = 1'b1;
        tick();
        chk("idle_after_reset_done", 64'(done), 64'd0);

        // Vector table
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 17'h0,     1'b0, 17'h0,     16'h1234, 5'd16, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0,    17'h0,     1'b0, 17'h0,     16'h2468, 5'd15, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h0,    17'h1FFFF, 1'b1, 17'h1FFFF, 16'h2469, 5'd15, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0,    17'h5,     1'b1, 17'h1FFFE, 16'h48D2, 5'd14, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h8001, 17'h7,     1'b1, 17'h0,     16'h8001, 5'd16, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0,    17'h0,     1'b0, 17'h1,     16'h0002, 5'd15, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 17'h1234,  1'b1, 17'h1,     16'h0002, 5'd15, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 16'h0,    17'h3,     1'b0, 17'h3,     16'h0002, 5'd15, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 16'h0,    17'h1FFFF, 1'b1, 17'h1FFFF, 16'h0003, 5'd15, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            ld = tbl[i].ld; shl = tbl[i].shl; wr_a = tbl[i].wr;
            din = tbl[i].din; a_in = tbl[i].ain; q_bit = tbl[i].qb;
            tick();
            chk($sformatf("vec%0d_a", i), 64'(a_out), 64'(tbl[i].ea));
            chk($sformatf("vec%0d_q", i), 64'(q_out), 64'(tbl[i].eq));
            chk($sformatf("vec%0d_cnt", i), 64'(cnt_out), 64'(tbl[i].ec));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(tbl[i].ed));
            chk($sformatf("vec%0d_ovr", i), 64'(overrun), 64'(tbl[i].eo));
        end
        idle();

        // Asynchronous reset mid-sequence at cnt=9
        ld = 1'b1; din = 16'hBEEF; tick(); ld = 1'b0;
        for (int i = 0; i < 7; i++) begin shl = 1'b1; tick(); end
        shl = 1'b0;
        chk("mid_cnt9", 64'(cnt_out), 64'd9);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_a", 64'(a_out), 64'd0);
        chk("async_rst_q", 64'(q_out), 64'd0);
        chk("async_rst_cnt", 64'(cnt_out), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_ovr", 64'(overrun), 64'd0);
        @(negedge clk); rst = 1'b1;
        tick();
        chk("post_rst_done_low", 64'(done), 64'd0);

        // Random command stream against a {A,Q} bit-vector model
        m_aq = '0; m_cnt = 0; m_loaded = 0; m_pend = 0; m_ovr = 0;
        for (int c = 0; c < 400; c++) begin
            ld    = ($urandom_range(0, 29) == 0);
            shl   = $urandom_range(0, 1);
            wr_a  = $urandom_range(0, 1);
            din   = W'($urandom);
            a_in  = (W+1)'($urandom);
            q_bit = $urandom_range(0, 1);
            if (ld) begin
                m_aq = {{(W+1){1'b0}}, din}; m_cnt = W; m_loaded = 1; m_pend = 0; m_ovr = 0;
            end else if (shl) begin
                if (m_cnt > 0) begin m_aq = m_aq << 1; m_cnt--; m_pend = 1; end
                else m_ovr = 1;
            end else if (wr_a) begin
                m_aq = {a_in, m_aq[W-1:1], q_bit}; m_pend = 0;
            end
            tick();
            chk("rnd_a", 64'(a_out), 64'(m_aq[2*W:W]));
            chk("rnd_q", 64'(q_out), 64'(m_aq[W-1:0]));
            chk("rnd_cnt", 64'(cnt_out), 64'(m_cnt));
            chk("rnd_done", 64'(done), 64'(m_loaded && m_cnt == 0 && !m_pend));
            chk("rnd_ovr", 64'(overrun), 64'(m_ovr));
        end
        idle();

        // Directed division 100 / 7, then misuse and reload
        div16(16'd100, 16'd7);
        shl = 1'b1; tick(); shl = 1'b0;
        chk("after_done_ovr", 64'(overrun), 64'd1);
        chk("after_done_a", 64'(a_out), 64'd2);
        chk("after_done_q", 64'(q_out), 64'd14);
        chk("after_done_done", 64'(done), 64'd1);
        tick();
        chk("ovr_sticky", 64'(overrun), 64'd1);
        ld = 1'b1; din = 16'd5; tick(); ld = 1'b0;
        chk("reload_ovr", 64'(overrun), 64'd0);
        chk("reload_done", 64'(done), 64'd0);
        chk("reload_cnt", 64'(cnt_out), 64'd16);
        chk("reload_q", 64'(q_out), 64'd5);
        chk("reload_a", 64'(a_out), 64'd0);

        // Random divisions
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] dd, dv;
            dd = W'($urandom);
            dv = W'($urandom_range(1, 65535));
            if (k % 4 == 0) dv = W'($urandom_range(1, 15));
            div16(dd, dv);
        end

        // Overrun cleared by reset
        shl = 1'b1; tick(); shl = 1'b0;
        chk("ovr_before_rst", 64'(overrun), 64'd1);
        #2 rst = 1'b0; #1;
        chk("rst_clears_ovr", 64'(overrun), 64'd0);
        chk("rst_clears_done", 64'(done), 64'd0);
        @(negedge clk); rst = 1'b1;
        tick();

        // WIDTH=8: 255 / 16 with cnt sequence and done latency
        begin
            logic [W8:0] diff8;
            int edges;
            ld8 = 1'b1; din8 = 8'd255; tick(); ld8 = 1'b0;
            edges = 1;
            chk("w8_cnt_load", 64'(cnt8), 64'd8);
            for (int i = 0; i < W8; i++) begin
                shl8 = 1'b1; tick(); shl8 = 1'b0; edges++;
                chk($sformatf("w8_cnt_step%0d", i), 64'(cnt8), 64'(7 - i));
                diff8 = aout8 - 9'd16;
                wr8 = 1'b1;
                if (diff8[W8]) begin ain8 = aout8; qb8 = 1'b0; end
                else           begin ain8 = diff8; qb8 = 1'b1; end
                chk($sformatf("w8_done_low%0d", i), 64'(done8), 64'd0);
                tick(); wr8 = 1'b0; edges++;
            end
            chk("w8_edges", 64'(edges), 64'd17);
            chk("w8_quotient", 64'(qout8), 64'd15);
            chk("w8_remainder", 64'(aout8), 64'd15);
            chk("w8_done", 64'(done8), 64'd1);
            chk("w8_cnt_end", 64'(cnt8), 64'd0);
            chk("w8_ovr", 64'(ovr8), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
